// File: rtl/cordic_norm4_if.sv
// -----------------------------------------------------------------------------
// cordic_norm4_if
//   Matrix-row streaming interface for the CORDIC norm block.
//   Request side : in_valid, matrix_0..matrix_3 (signed Q8.3 row elements)
//   Response side: out_valid, out_matrix (signed Q8.3 Euclidean norm)
//   master modport : drives the request side and observes the response side
//   slave  modport : consumes the request side and drives the response side
// -----------------------------------------------------------------------------
interface cordic_norm4_if #(
    parameter int DATA_W = 12
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] matrix_0;
    logic signed [DATA_W-1:0] matrix_1;
    logic signed [DATA_W-1:0] matrix_2;
    logic signed [DATA_W-1:0] matrix_3;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_matrix;

    modport master (
        output in_valid, matrix_0, matrix_1, matrix_2, matrix_3,
        input  out_valid, out_matrix
    );

    modport slave (
        input  in_valid, matrix_0, matrix_1, matrix_2, matrix_3,
        output out_valid, out_matrix
    );
endinterface

// File: rtl/cordic_norm4.sv
// -----------------------------------------------------------------------------
// cordic_norm4
//   Fully pipelined Euclidean norm of a 4-element signed Q8.3 row.
//   Two parallel CORDIC vectoring rotators reduce (|m0|,m1) and (|m2|,m3) to
//   their magnitudes, a third rotator combines those two magnitudes, and a
//   constant multiply removes the K^2 CORDIC gain before round/saturate.
//   One row per cycle, no backpressure, latency 2*ITER+2 cycles.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset (clears all valid bits)
//     bus  - cordic_norm4_if.slave: in_valid/matrix_0..3 in,
//            out_valid/out_matrix out (out_matrix is 0 when out_valid is 0)
// -----------------------------------------------------------------------------
module cordic_norm4 #(
    parameter int DATA_W = 12,
    parameter int ITER   = 12,
    parameter int GUARD  = 2,
    parameter int KINV2  = 24167
) (
    input  logic          clk,
    input  logic          rst,
    cordic_norm4_if.slave bus
);
    localparam int IW   = DATA_W + GUARD + 3;
    localparam int PW   = 34;
    localparam int OMAX = (1 << (DATA_W - 1)) - 1;

    typedef logic signed [IW-1:0] iw_t;
    typedef struct packed {
        iw_t x;
        iw_t y;
    } vec_t;

    // Sign-extend a sample to the internal width and add the guard bits.
    function automatic iw_t widen(input logic signed [DATA_W-1:0] m);
        iw_t w;
        w = {{(IW - DATA_W){m[DATA_W-1]}}, m};
        return w <<< GUARD;
    endfunction

    function automatic iw_t iabs(input iw_t v);
        return (v < 0) ? -v : v;
    endfunction

    // One vectoring micro-rotation: drive y toward zero, both updates use
    // the pre-update x and y.
    function automatic vec_t rotate(input vec_t v, input int sh);
        iw_t  x;
        iw_t  y;
        vec_t r;
        x = v.x;
        y = v.y;
        if (y >= 0) begin
            r.x = x + (y >>> sh);
            r.y = y - (x >>> sh);
        end else begin
            r.x = x - (y >>> sh);
            r.y = y + (x >>> sh);
        end
        return r;
    endfunction

    // Stage-A rotators: index 0 is the input register, index i+1 holds the
    // result of micro-rotation i.
    vec_t ra_q [ITER+1];
    vec_t ra_d [ITER+1];
    vec_t rb_q [ITER+1];
    vec_t rb_d [ITER+1];
    logic [ITER:0] va_q, va_d;

    // Stage-B rotator: index i holds the result of micro-rotation i.
    vec_t s2_q [ITER];
    vec_t s2_d [ITER];
    logic [ITER-1:0] vb_q, vb_d;
    vec_t b_in;

    // Gain-compensation product, then the rounded/saturated output.
    logic signed [PW-1:0]     p_q, p_d;
    logic                     vp_q, vp_d;
    logic signed [PW-1:0]     n;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_matrix_q, out_matrix_d;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch; blocking '=' is correct here
    // because later statements must see the freshly computed values.
    always_comb begin
        ra_d = ra_q;
        rb_d = rb_q;
        s2_d = s2_q;
        va_d = '0;
        vb_d = '0;

        // Hold stage 0 on idle cycles so undefined matrix_* never enters
        // the datapath.
        if (bus.in_valid) begin
            ra_d[0].x = iabs(widen(bus.matrix_0));
            ra_d[0].y = widen(bus.matrix_1);
            rb_d[0].x = iabs(widen(bus.matrix_2));
            rb_d[0].y = widen(bus.matrix_3);
        end
        va_d[0] = bus.in_valid;

        for (int i = 0; i < ITER; i++) begin
            ra_d[i+1]  = rotate(ra_q[i], i);
            rb_d[i+1]  = rotate(rb_q[i], i);
            va_d[i+1]  = va_q[i];
        end

        // Combine the two partial magnitudes (each already carries gain K).
        b_in.x  = ra_q[ITER].x;
        b_in.y  = rb_q[ITER].x;
        s2_d[0] = rotate(b_in, 0);
        vb_d[0] = va_q[ITER];
        for (int i = 1; i < ITER; i++) begin
            s2_d[i] = rotate(s2_q[i-1], i);
            vb_d[i] = vb_q[i-1];
        end

        p_d  = PW'($signed(s2_q[ITER-1].x)) * PW'(KINV2);
        vp_d = vb_q[ITER-1];

        // Drop the 16-bit gain fraction and the guard bits, rounding half up.
        n = (p_q + (PW'(1) <<< (15 + GUARD))) >>> (16 + GUARD);

        out_valid_d = vp_q;
        if (!vp_q) begin
            out_matrix_d = '0;
        end else if (n > PW'(OMAX)) begin
            out_matrix_d = DATA_W'(OMAX);
        end else if (n < 0) begin
            out_matrix_d = '0;
        end else begin
            out_matrix_d = n[DATA_W-1:0];
        end
    end

    // Control path: valid bits and the output register are cleared by reset,
    // which is enough to discard every in-flight row.
    always_ff @(posedge clk) begin
        if (rst) begin
            va_q         <= '0;
            vb_q         <= '0;
            vp_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_matrix_q <= '0;
        end else begin
            va_q         <= va_d;
            vb_q         <= vb_d;
            vp_q         <= vp_d;
            out_valid_q  <= out_valid_d;
            out_matrix_q <= out_matrix_d;
        end
    end

    // NOTE: the wide datapath registers are deliberately not reset; their
    // contents only matter when the matching valid bit is set, and leaving
    // them reset-free keeps the reset net off hundreds of flops.
    always_ff @(posedge clk) begin
        ra_q <= ra_d;
        rb_q <= rb_d;
        s2_q <= s2_d;
        p_q  <= p_d;
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_matrix = out_matrix_q;
endmodule

// File: doc/cordic_norm4.md
Name: cordic_norm4

Overview:
- Streaming receiver for the matrix row interface: in_valid plus matrix_0..matrix_3.
- For every row accepted, it computes the Euclidean norm of the 4-element row using cascaded CORDIC vectoring.
- Result is returned on the out_valid/out_matrix side of the same interface, in the same Q8.3 format.
- Fully pipelined: it accepts one row per cycle, so a 32-row burst yields a 32-cycle output burst, order preserved, no backpressure.

Parameters:
- DATA_W, 12, signed sample width; Q8.3 (sign, 8 integer, 3 fraction bits).
- ITER, 12, CORDIC micro-rotations per vectoring stage (one pipeline stage each).
- GUARD, 2, extra fractional guard bits in the internal datapath.
- KINV2, 24167, round(2^16 / K^2), K = 1.646760 (12-iteration gain).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  row valid; row sampled on the rising edge where it is high.
- matrix_0  in  DATA_W  signed row element 0.
- matrix_1  in  DATA_W  signed row element 1.
- matrix_2  in  DATA_W  signed row element 2.
- matrix_3  in  DATA_W  signed row element 3.
- out_valid  out  1  result valid, one cycle per accepted row.
- out_matrix  out  DATA_W  signed norm in Q8.3; 0 whenever out_valid is 0.

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-high. While rst is high at an edge:
  - out_valid = 0 and out_matrix = 0.
  - All pipeline valid bits are cleared.
  - Data registers may be held or cleared, but must never reach the outputs as valid data.
- Reset mid-burst: all in-flight rows are discarded, and no out_valid pulse is produced for them.
- Internal width: IW = DATA_W + GUARD + 3 = 17 bits, signed. Inputs are sign-extended and shifted left by GUARD.
- Input register (stage 0), loaded when in_valid is high:
  - xa = |m0|, ya = m1, xb = |m2|, yb = m3.
  - Abs of -2048 = +2048, which is representable in IW.
- Stage A (ITER stages, i = 0..ITER-1): two parallel vectoring rotators.
  - If y >= 0: x' = x + (y >>> i), y' = y - (x >>> i).
  - Else: x' = x - (y >>> i), y' = y + (x >>> i).
  - Uses the pre-update x and y; arithmetic shift.
  - Outputs: r1 = xa_final, r2 = xb_final (both >= 0, gain K).
- Stage B (ITER stages): same rotator with x0 = r1, y0 = r2. Output xf, with gain K^2.
- Scale / saturate stage:
  - p = xf * KINV2, 34-bit signed.
  - n = (p + 2^(15+GUARD)) >>> (16 + GUARD), rounding half up.
  - out_matrix = min(n, 2047); the result is never negative.
- Latency: a row sampled at edge k produces out_valid = 1 after edge k + LAT, with LAT = 2*ITER + 2 (26 by default).
- Pipeline: a valid bit travels with each stage. Stages advance every cycle unconditionally, with no stall.
- Gaps in in_valid propagate as out_valid = 0 bubbles of identical length and position. Row order is preserved.
- Burst end: out_valid falls the cycle after the last result. Back-to-back bursts need no idle gap.
- Accuracy: |out_matrix - exact_norm_in_LSB| <= 2 for every non-saturated row.
- Overflow: no internal overflow for any input, since the worst-case xf of about 44.5k is below 2^16.
- in_valid = 0: matrix_* may be X; X must never propagate to out_matrix.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid = 0 -> out_valid = 0 and out_matrix = 0 during reset and after release.
- Basic norms, one 4-row burst:
  - (24,32,0,0) -> 40 (5.0).
  - (64,0,0,0) -> 64.
  - (8,8,8,8) -> 16.
  - (-64,-64,-64,-64) -> 128.
  - Each within ±2, with out_valid rising exactly 26 cycles after the first sample and staying high 4 cycles.
- 32-row random burst (values in ±1024 raw) -> 32 consecutive out_valid cycles, each within ±2 of a real-valued reference; out_valid = 0 on the following cycle.
- Saturation: rows (2047,2047,2047,2047) and (-2048,-2048,-2048,-2048) -> out_matrix = 2047 for both.
- Bubbles: in_valid pattern 1,0,0,1,1 with rows (24,32,0,0) / (0,0,0,-40) / (0,16,0,12) -> out_valid pattern 1,0,0,1,1 shifted by 26 cycles, values 40, 40, 20.
- Reset mid-operation: assert rst 10 cycles into a 32-row burst, release, then send row (24,32,0,0) -> no output from the aborted burst; a single out_valid pulse with 40 at LAT cycles after the new sample.
